// File: rtl/seq_sched_pkg.sv
// seq_sched_pkg: shared types and sequencer latency constants for seq_run_scheduler
package seq_sched_pkg;
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_LOOP} state_t;
  typedef logic req_id_t;
  localparam int unsigned SEQ_FIRST_LAT = 5;
  localparam int unsigned SEQ_LOOP_LAT  = 5;
endpackage

// File: rtl/seq_run_scheduler_rr_arb2.sv
// rr_arb2: two-way round-robin arbiter; ports i_clk, i_reset, i_req[1:0], i_upd (served strobe), i_id (served index), o_gnt[1:0] one-hot
module rr_arb2
  import seq_sched_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic [1:0] i_req,
  input  logic       i_upd,
  input  req_id_t    i_id,
  output logic [1:0] o_gnt
);
  req_id_t r_ptr;
  always_ff @(posedge i_clk)
    if (i_reset) r_ptr <= 1'b0;
    else if (i_upd) r_ptr <= ~i_id;
  assign o_gnt = (&i_req) ? (r_ptr ? 2'b10 : 2'b01) : i_req;
endmodule

// File: rtl/seq_run_scheduler.sv
// seq_run_scheduler: grants the shared five-state sequencer round-robin to two requesters and runs it
// Ports: i_clk, i_reset (sync, active-high); i_req/i_hold[1:0] per requester; i_loops0/1 loop counts;
// o_gnt one-hot grant, o_busy, o_done/o_done_id, o_aborted, o_err pulses; o_seq_* sequencer controls; i_seq_terminal.
// Optional watchdog enabled by defining SEQ_SCHED_TIMEOUT_EN.
module seq_run_scheduler
  import seq_sched_pkg::*;
#(
  parameter int LOOP_W      = 3,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic [1:0]        i_req,
  input  logic [1:0]        i_hold,
  input  logic [LOOP_W-1:0] i_loops0,
  input  logic [LOOP_W-1:0] i_loops1,
  output logic [1:0]        o_gnt,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_done_id,
  output logic              o_aborted,
  output logic              o_err,
  output logic              o_seq_restart,
  output logic              o_seq_pause,
  output logic              o_seq_go_to_third,
  input  logic              i_seq_terminal
);
  state_t            r_state, w_state_n;
  logic [1:0]        r_gnt, w_gnt_n, w_arb_gnt;
  req_id_t           r_id, w_id_n;
  logic [LOOP_W-1:0] r_loops, w_loops_n;
  logic              r_busy, w_busy_n, r_done, w_done_n, r_done_id, w_done_id_n;
  logic              r_aborted, w_aborted_n, r_err, w_err_n;
  logic              r_restart, w_restart_n, r_pause, w_pause_n, r_g3, w_g3_n;
  logic              w_end, w_upd, w_tmo;
  rr_arb2 u_arb (
    .i_clk  (i_clk),
    .i_reset(i_reset),
    .i_req  (i_req),
    .i_upd  (w_upd),
    .i_id   (r_id),
    .o_gnt  (w_arb_gnt)
  );
`ifdef SEQ_SCHED_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  logic [CNT_W-1:0] r_cnt;
  logic             w_to_loop;
  assign w_to_loop = (r_state == S_RUN) && (w_state_n == S_LOOP);
  always_ff @(posedge i_clk)
    if (i_reset || r_state == S_IDLE || w_to_loop) r_cnt <= '0;
    else r_cnt <= r_cnt + 1'b1;
  assign w_tmo = (r_state != S_IDLE) && (r_cnt == CNT_W'(TIMEOUT_CYC - 1));
`else
  assign w_tmo = 1'b0 & (TIMEOUT_CYC == 0);
`endif
  always_comb begin
    w_state_n   = r_state;
    w_gnt_n     = r_gnt;
    w_id_n      = r_id;
    w_loops_n   = r_loops;
    w_busy_n    = r_busy;
    w_done_n    = 1'b0;
    w_done_id_n = r_done_id;
    w_aborted_n = 1'b0;
    w_err_n     = 1'b0;
    w_restart_n = r_restart;
    w_pause_n   = r_pause;
    w_g3_n      = 1'b0;
    w_end       = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_restart_n = 1'b1;
        w_pause_n   = 1'b1;
        if (!i_seq_terminal && |i_req) begin
          w_gnt_n     = w_arb_gnt;
          w_id_n      = w_arb_gnt[1];
          w_loops_n   = w_arb_gnt[1] ? i_loops1 : i_loops0;
          w_busy_n    = 1'b1;
          w_restart_n = 1'b0;
          w_pause_n   = 1'b0;
          w_state_n   = S_RUN;
        end
      end
      S_RUN: begin
        w_restart_n = 1'b0;
        w_pause_n   = i_hold[r_id];
        if (!i_req[r_id] || w_tmo) begin
          w_aborted_n = 1'b1;
          w_err_n     = i_req[r_id];
          w_end       = 1'b1;
        end else if (i_seq_terminal && r_loops != '0) begin
          w_g3_n    = 1'b1;
          w_loops_n = r_loops - 1'b1;
          w_state_n = S_LOOP;
        end else if (i_seq_terminal) begin
          w_done_n    = 1'b1;
          w_done_id_n = r_id;
          w_end       = 1'b1;
        end
      end
      S_LOOP: begin
        w_restart_n = 1'b0;
        w_pause_n   = i_hold[r_id];
        if (!i_req[r_id] || w_tmo) begin
          w_aborted_n = 1'b1;
          w_err_n     = i_req[r_id];
          w_end       = 1'b1;
        end else if (!i_seq_terminal) w_state_n = S_RUN;
      end
      default: w_state_n = S_IDLE;
    endcase
    if (w_end) begin
      w_gnt_n     = 2'b00;
      w_busy_n    = 1'b0;
      w_restart_n = 1'b1;
      w_pause_n   = 1'b1;
      w_state_n   = S_IDLE;
    end
    w_upd = w_end;
  end
  always_ff @(posedge i_clk)
    if (i_reset) begin
      r_state   <= S_IDLE;
      r_gnt     <= 2'b00;
      r_id      <= 1'b0;
      r_loops   <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_done_id <= 1'b0;
      r_aborted <= 1'b0;
      r_err     <= 1'b0;
      r_restart <= 1'b1;
      r_pause   <= 1'b1;
      r_g3      <= 1'b0;
    end else begin
      r_state   <= w_state_n;
      r_gnt     <= w_gnt_n;
      r_id      <= w_id_n;
      r_loops   <= w_loops_n;
      r_busy    <= w_busy_n;
      r_done    <= w_done_n;
      r_done_id <= w_done_id_n;
      r_aborted <= w_aborted_n;
      r_err     <= w_err_n;
      r_restart <= w_restart_n;
      r_pause   <= w_pause_n;
      r_g3      <= w_g3_n;
    end
  assign o_gnt             = r_gnt;
  assign o_busy            = r_busy;
  assign o_done            = r_done;
  assign o_done_id         = r_done_id;
  assign o_aborted         = r_aborted;
  assign o_err             = r_err;
  assign o_seq_restart     = r_restart;
  assign o_seq_pause       = r_pause;
  assign o_seq_go_to_third = r_g3;
endmodule

// File: tb/tb_seq_run_scheduler.sv
// tb_seq_run_scheduler: self-checking bench with a behavioural sequencer and an expected-completion queue
module tb_seq_run_scheduler;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] req = 2'b00, hold = 2'b00;
  logic [2:0] loops0 = 3'd0, loops1 = 3'd0;
  logic [1:0] gnt;
  logic       busy, done, done_id, aborted, err;
  logic       seq_restart, seq_pause, seq_g3, seq_terminal;
  typedef struct {logic id; int lat; logic abort;} exp_t;
  exp_t q[$];
  int checks = 0, errors = 0, cyc = 0;
  int g3_hi = 0, g3_rise = 0, done_cnt = 0, err_cnt = 0;
  logic g3_prev = 1'b0;
  int sst = 0;
  logic sterm = 1'b0;
  localparam logic [10:0] RST_V = 11'b00000000110;
  seq_run_scheduler #(.LOOP_W(3), .TIMEOUT_CYC(16)) dut (
    .i_clk(clk), .i_reset(reset), .i_req(req), .i_hold(hold),
    .i_loops0(loops0), .i_loops1(loops1), .o_gnt(gnt), .o_busy(busy),
    .o_done(done), .o_done_id(done_id), .o_aborted(aborted), .o_err(err),
    .o_seq_restart(seq_restart), .o_seq_pause(seq_pause),
    .o_seq_go_to_third(seq_g3), .i_seq_terminal(seq_terminal)
  );
  assign seq_terminal = sterm;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk)
    if (seq_restart === 1'b1) begin
      sst <= 0;
      sterm <= 1'b0;
    end else begin
      sterm <= (sst == 4);
      if (seq_g3 === 1'b1) sst <= 2;
      else if (seq_pause === 1'b0 && sst != 4) sst <= sst + 1;
    end
  always @(negedge clk) begin
    if (seq_g3 === 1'b1) g3_hi++;
    if (seq_g3 === 1'b1 && !g3_prev) g3_rise++;
    g3_prev = (seq_g3 === 1'b1);
    if (done === 1'b1) done_cnt++;
    if (err === 1'b1) err_cnt++;
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic idle(input int n);
    repeat (n) tick();
  endtask
  task automatic wait_gnt(output int t);
    t = -1;
    for (int i = 0; i < 50 && t < 0; i++) begin
      tick();
      if (gnt !== 2'b00) t = cyc;
    end
  endtask
  task automatic wait_end(output int t, output logic [1:0] k);
    t = -1;
    k = 2'b00;
    for (int i = 0; i < 100 && t < 0; i++) begin
      tick();
      if (done === 1'b1 || aborted === 1'b1) begin
        t = cyc;
        k = {aborted, done};
      end
    end
  endtask
  task automatic test_reset();
    reset = 1'b1;
    idle(2);
    checks++;
    if ({gnt, busy, done, done_id, aborted, err, seq_restart, seq_pause, seq_g3} !== RST_V) begin
      errors++;
      $display("FAIL reset_vals got %b want %b", {gnt, busy, done, done_id, aborted, err, seq_restart, seq_pause, seq_g3}, RST_V);
    end
    reset = 1'b0;
    idle(2);
  endtask
  task automatic test_single();
    int t0, t;
    logic [1:0] k;
    exp_t e;
    loops0 = 3'd0;
    req = 2'b01;
    wait_gnt(t0);
    checks++;
    if (gnt !== 2'b01 || busy !== 1'b1) begin errors++; $display("FAIL single_gnt got %b/%b want 01/1", gnt, busy); end
    q.push_back('{id: 1'b0, lat: 6, abort: 1'b0});
    wait_end(t, k);
    req = 2'b00;
    e = q.pop_front();
    checks++;
    if (k !== 2'b01 || t - t0 != e.lat) begin errors++; $display("FAIL single_done kind %b lat %0d want 01 lat %0d", k, t - t0, e.lat); end
    checks++;
    if (done_id !== e.id || seq_restart !== 1'b1 || gnt !== 2'b00) begin
      errors++;
      $display("FAIL single_end id %b restart %b gnt %b want %b 1 00", done_id, seq_restart, gnt, e.id);
    end
    idle(4);
  endtask
  task automatic test_loops();
    int t0, t;
    logic [1:0] k;
    exp_t e;
    loops1 = 3'd2;
    g3_hi = 0;
    g3_rise = 0;
    req = 2'b10;
    wait_gnt(t0);
    checks++;
    if (gnt !== 2'b10) begin errors++; $display("FAIL loops_gnt got %b want 10", gnt); end
    q.push_back('{id: 1'b1, lat: 16, abort: 1'b0});
    wait_end(t, k);
    req = 2'b00;
    e = q.pop_front();
    checks++;
    if (k !== 2'b01 || t - t0 != e.lat || done_id !== e.id) begin
      errors++;
      $display("FAIL loops_done kind %b lat %0d id %b want 01 lat %0d id %b", k, t - t0, done_id, e.lat, e.id);
    end
    checks++;
    if (g3_hi != 2 || g3_rise != 2) begin errors++; $display("FAIL loops_g3 cycles %0d pulses %0d want 2 2", g3_hi, g3_rise); end
    loops1 = 3'd0;
    idle(4);
  endtask
  task automatic test_back_to_back();
    int t0, t, t_prev;
    logic [1:0] k;
    logic [1:0] want;
    exp_t e;
    reset = 1'b1;
    idle(2);
    reset = 1'b0;
    req = 2'b11;
    t_prev = -1;
    for (int i = 0; i < 3; i++) begin
      want = (i == 1) ? 2'b10 : 2'b01;
      wait_gnt(t0);
      checks++;
      if (gnt !== want) begin errors++; $display("FAIL b2b_gnt%0d got %b want %b", i, gnt, want); end
      if (t_prev >= 0) begin
        checks++;
        if (t0 - t_prev != 2) begin errors++; $display("FAIL b2b_gap%0d got %0d want 2", i, t0 - t_prev); end
      end
      q.push_back('{id: want[1], lat: 6, abort: 1'b0});
      wait_end(t, k);
      if (i == 2) req = 2'b00;
      e = q.pop_front();
      checks++;
      if (k !== 2'b01 || t - t0 != e.lat || done_id !== e.id) begin
        errors++;
        $display("FAIL b2b_done%0d kind %b lat %0d id %b want 01 lat %0d id %b", i, k, t - t0, done_id, e.lat, e.id);
      end
      t_prev = t;
    end
    idle(4);
  endtask
  task automatic test_hold();
    int t0, t;
    logic [1:0] k;
    exp_t e;
    hold = 2'b10;
    for (int r = 0; r < 2; r++) begin
      req = 2'b01;
      wait_gnt(t0);
      q.push_back('{id: 1'b0, lat: (r == 0) ? 6 : 9, abort: 1'b0});
      if (r == 1) begin
        tick();
        hold = 2'b11;
        idle(3);
        hold = 2'b10;
      end
      wait_end(t, k);
      req = 2'b00;
      e = q.pop_front();
      checks++;
      if (k !== 2'b01 || t - t0 != e.lat) begin errors++; $display("FAIL hold%0d kind %b lat %0d want 01 lat %0d", r, k, t - t0, e.lat); end
      idle(4);
    end
    hold = 2'b00;
  endtask
  task automatic test_abort();
    int t0, t, d0;
    logic [1:0] k;
    exp_t e;
    d0 = done_cnt;
    loops0 = 3'd1;
    req = 2'b01;
    wait_gnt(t0);
    q.push_back('{id: 1'b0, lat: 4, abort: 1'b1});
    idle(3);
    req = 2'b00;
    wait_end(t, k);
    e = q.pop_front();
    checks++;
    if (k !== 2'b10 || t - t0 != e.lat) begin errors++; $display("FAIL abort_evt kind %b lat %0d want 10 lat %0d", k, t - t0, e.lat); end
    checks++;
    if (gnt !== 2'b00 || busy !== 1'b0 || seq_restart !== 1'b1 || seq_pause !== 1'b1 || err !== 1'b0) begin
      errors++;
      $display("FAIL abort_outs gnt %b busy %b rst %b pause %b err %b want 00 0 1 1 0", gnt, busy, seq_restart, seq_pause, err);
    end
    req = 2'b11;
    wait_gnt(t0);
    checks++;
    if (gnt !== 2'b10) begin errors++; $display("FAIL abort_ptr got %b want 10", gnt); end
    req = 2'b00;
    wait_end(t, k);
    idle(10);
    checks++;
    if (done_cnt != d0) begin errors++; $display("FAIL abort_nodone got %0d want %0d", done_cnt - d0, 0); end
    loops0 = 3'd0;
    req = 2'b01;
    wait_gnt(t0);
    idle(2);
    reset = 1'b1;
    tick();
    checks++;
    if ({gnt, busy, done, done_id, aborted, err, seq_restart, seq_pause, seq_g3} !== RST_V) begin
      errors++;
      $display("FAIL midrun_reset got %b want %b", {gnt, busy, done, done_id, aborted, err, seq_restart, seq_pause, seq_g3}, RST_V);
    end
    req = 2'b00;
    reset = 1'b0;
    idle(4);
  endtask
  task automatic test_timeout();
    int t0, t;
    logic [1:0] k;
    loops0 = 3'd0;
    req = 2'b01;
    wait_gnt(t0);
    hold = 2'b01;
    idle(20);
    hold = 2'b00;
`ifdef SEQ_SCHED_TIMEOUT_EN
    checks++;
    if (err_cnt != 1) begin errors++; $display("FAIL timeout_err count %0d want 1", err_cnt); end
    checks++;
    if (busy !== 1'b0 || gnt !== 2'b00) begin errors++; $display("FAIL timeout_idle busy %b gnt %b want 0 00", busy, gnt); end
    req = 2'b00;
`else
    wait_end(t, k);
    req = 2'b00;
    checks++;
    if (k !== 2'b01 || t - t0 != 26) begin errors++; $display("FAIL hold20_done kind %b lat %0d want 01 lat 26", k, t - t0); end
    checks++;
    if (err_cnt != 0) begin errors++; $display("FAIL err_tied got %0d want 0", err_cnt); end
`endif
    idle(4);
  endtask
`ifdef SEQ_SCHED_TIMEOUT_EN
  always @(negedge clk)
    if (err === 1'b1) begin
      checks++;
      if (aborted !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL err_with_abort aborted %b busy %b want 1 0", aborted, busy); end
    end
`endif
  initial begin
    test_reset();
    test_single();
    test_loops();
    test_back_to_back();
    test_hold();
    test_abort();
    test_timeout();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
endmodule

// File: doc/seq_run_scheduler.md
# seq_run_scheduler

Shares the five-state step sequencer (first→second→third→fourth→fifth, outputs registered one cycle behind state) between two requesters. Grants the sequencer round-robin, drives its restart/pause/go_to_third inputs to execute one run (restart, advance to fifth, optionally loop fifth→third N times), and reports completion. Sits between requester logic and the sequencer instance in the top level.

## Interface
- LOOP_W, 3, width of per-requester loop count
- TIMEOUT_CYC, 16, watchdog limit in cycles (used only with timeout feature)

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- req  in  2  run request per requester; level, held until done
- hold  in  2  per-requester freeze; honoured only for the granted requester
- loops0, loops1  in  LOOP_W  fifth→third loop count, sampled at grant
- gnt  out  2  one-hot grant, 0 when idle
- busy  out  1  run in progress
- done  out  1  one-cycle pulse, run completed
- done_id  out  1  requester index of the completed run, valid with done
- aborted  out  1  one-cycle pulse, run abandoned
- err  out  1  one-cycle pulse, watchdog expiry
- seq_restart, seq_pause, seq_go_to_third  out  1 each  sequencer controls
- seq_terminal  in  1  sequencer terminal output

## Operation
- All outputs registered. Reset values: gnt=0, busy=0, done=0, done_id=0, aborted=0, err=0, seq_restart=1, seq_pause=1, seq_go_to_third=0; state IDLE; round-robin pointer selects requester 0 first.
- IDLE: restart=pause=1 (sequencer parked in first). Grant only when seq_terminal=0 and some req=1. One request: grant it. Both: grant the one not served last. At grant: latch loop count, gnt, busy=1, restart=pause=0, go RUN.
- RUN: restart=0, go_to_third=0, pause=hold[granted]. On seq_terminal=1: loop count >0 → go_to_third=1 for exactly one cycle, decrement, go LOOP; loop count =0 → done=1, done_id, gnt=0, busy=0, restart=pause=1, pointer updated, go IDLE.
- LOOP: restart=0, pause=hold[granted]; wait for seq_terminal=0, then RUN.
- Abort: granted req drops in RUN or LOOP → aborted=1, gnt=0, busy=0, restart=pause=1, go IDLE; no done. Pointer updated as if completed.
- Non-granted req/hold ignored during a run.
- Reset mid-run: all outputs return to reset values at the next edge, no done/aborted.

## Timing
- Grant edge = e0. Sequencer: e1 second, e2 third, e3 fourth, e4 fifth, e5 seq_terminal=1, e6 done (loops=0).
- Each loop adds 5 cycles: done at e6+5·loops, absent hold.
- Each hold cycle in RUN/LOOP (before fifth) delays done by one cycle.
- After done, earliest next grant is 2 cycles later (seq_terminal clears).

## Configuration
- SEQ_SCHED_TIMEOUT_EN defined: counter clears at grant and at every RUN→LOOP transition, counts in RUN/LOOP; reaching TIMEOUT_CYC → err=1 and abort sequence (aborted=1, IDLE). Hold cycles count.
- Undefined: no counter, err tied 0, TIMEOUT_CYC unused.

## Structure
- Package seq_sched_pkg: state enum (IDLE, RUN, LOOP), requester index type, sequencer step-latency constants (5 to first terminal, 5 per loop).
- Sub-module rr_arb2: two-way round-robin arbiter, inputs req[1:0] and update strobe, output one-hot grant.

## Test plan
- req=01, loops0=0 → gnt=01 at e0, done=1 with done_id=0 at e6, seq_restart=1 at e6.
- req=10, loops1=2 → exactly two single-cycle seq_go_to_third pulses, done at e16, done_id=1.
- req=11 from reset, held → grants alternate 01,10,01; each grant 2 cycles after the previous done.
- Granted requester holds 3 cycles at e2 → done at e9; hold on non-granted requester → no effect.
- req0 drops at e3 → aborted=1 at e4, gnt=0, seq_restart=seq_pause=1, no done; reset asserted mid-run → reset values next edge.
- With SEQ_SCHED_TIMEOUT_EN, TIMEOUT_CYC=16, hold held 20 cycles → err=1 and aborted=1 same cycle, busy=0; without macro, err stays 0.
